// File: rtl/interboard_rx_if.sv
// Four-phase request/acknowledge link from the peer board: 6-bit payload plus parity bit.
interface interboard_rx_if;
    logic       rx_req;
    logic [6:0] rx_data;
    logic       rx_ack;

    modport master (output rx_req, output rx_data, input rx_ack);
    modport slave  (input rx_req, input rx_data, output rx_ack);
endinterface

// File: rtl/interboard_rx.sv
// Receives 4-word packets over a 4-phase handshake and decodes them into message fields.
// Optional odd-parity checking per word is enabled by defining INTERBOARD_RX_PARITY_EN.
module interboard_rx #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 interboard_rst_i,
    interboard_rx_if.slave       rx,
    output logic                 interboard_en_o,
    output logic [3:0]           interboard_msg_type_o,
    output logic                 interboard_move_dir_o,
    output logic [4:0]           interboard_block_x_o,
    output logic [2:0]           interboard_block_y_o,
    output logic [2:0]           interboard_sel_len_o,
    output logic [5:0]           interboard_card_o,
    output logic                 rx_err_o
);

    localparam logic [16:0] TimeoutM1 = 17'(TIMEOUT - 1);

    typedef enum logic [0:0] {StRecv, StWaitRel} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [16:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        en_q, en_d;
    logic        err_q, err_d;
    logic [5:0]  w0_q, w0_d;
    logic [4:0]  w1_q, w1_d;
    logic [5:0]  w2_q, w2_d;
    logic [5:0]  w3_q, w3_d;
    logic [3:0]  type_q, type_d;
    logic        dir_q, dir_d;
    logic [4:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [2:0]  len_q, len_d;
    logic [5:0]  card_q, card_d;
    logic        req_meta_q, req_s_q;
    logic [5:0]  payload;
    logic        pkt_ok;
    logic        counting;

    assign payload = rx.rx_data[5:0];

`ifdef INTERBOARD_RX_PARITY_EN
    logic bad_q, bad_d;
    assign pkt_ok = (w0_q[5:2] <= 4'd8) && !bad_q;
`else
    logic unused_parity_bit;
    assign unused_parity_bit = rx.rx_data[6];
    assign pkt_ok = (w0_q[5:2] <= 4'd8);
`endif

    // Only req_s_q may be used by logic; req_meta_q may be metastable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else if (interboard_rst_i) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= rx.rx_req;
            req_s_q    <= req_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = ack_q;
        en_d     = 1'b0;
        err_d    = 1'b0;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        w3_d     = w3_q;
        type_d   = type_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        len_d    = len_q;
        card_d   = card_q;
        counting = 1'b0;
`ifdef INTERBOARD_RX_PARITY_EN
        bad_d    = bad_q;
`endif

        unique case (state_q)
            StRecv: begin
                if (req_s_q) begin
                    state_d = StWaitRel;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    unique case (idx_q)
                        2'd0: w0_d = payload;
                        2'd1: w1_d = payload[4:0];
                        2'd2: w2_d = payload;
                        2'd3: w3_d = payload;
                    endcase
`ifdef INTERBOARD_RX_PARITY_EN
                    bad_d = bad_q | ~(^rx.rx_data);
`endif
                end else if (idx_q != 2'd0) begin
                    counting = 1'b1;
                end
            end
            StWaitRel: begin
                if (!req_s_q) begin
                    state_d = StRecv;
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
`ifdef INTERBOARD_RX_PARITY_EN
                        bad_d = 1'b0;
`endif
                        if (pkt_ok) begin
                            en_d   = 1'b1;
                            type_d = w0_q[5:2];
                            dir_d  = w0_q[1];
                            x_d    = w1_q;
                            y_d    = w2_q[5:3];
                            len_d  = w2_q[2:0];
                            card_d = w3_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        idx_d = 2'(idx_q + 2'd1);
                    end
                end else begin
                    counting = 1'b1;
                end
            end
            default: begin
                state_d = StRecv;
                idx_d   = 2'd0;
                ack_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Abort lands on the edge where the counter would reach TIMEOUT.
        if (counting) begin
            if (cnt_q == TimeoutM1) begin
                state_d = StRecv;
                idx_d   = 2'd0;
                ack_d   = 1'b0;
                cnt_d   = '0;
                err_d   = 1'b1;
`ifdef INTERBOARD_RX_PARITY_EN
                bad_d   = 1'b0;
`endif
            end else begin
                cnt_d = 17'(cnt_q + 17'd1);
            end
        end

        if (interboard_rst_i) begin
            state_d = StRecv;
            idx_d   = 2'd0;
            cnt_d   = '0;
            ack_d   = 1'b0;
            en_d    = 1'b0;
            err_d   = 1'b0;
            w0_d    = '0;
            w1_d    = '0;
            w2_d    = '0;
            w3_d    = '0;
            type_d  = '0;
            dir_d   = 1'b0;
            x_d     = '0;
            y_d     = '0;
            len_d   = '0;
            card_d  = '0;
`ifdef INTERBOARD_RX_PARITY_EN
            bad_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRecv;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            type_q  <= '0;
            dir_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            len_q   <= '0;
            card_q  <= '0;
`ifdef INTERBOARD_RX_PARITY_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            err_q   <= err_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            type_q  <= type_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            len_q   <= len_d;
            card_q  <= card_d;
`ifdef INTERBOARD_RX_PARITY_EN
            bad_q   <= bad_d;
`endif
        end
    end

    assign rx.rx_ack             = ack_q;
    assign interboard_en_o       = en_q;
    assign rx_err_o              = err_q;
    assign interboard_msg_type_o = type_q;
    assign interboard_move_dir_o = dir_q;
    assign interboard_block_x_o  = x_q;
    assign interboard_block_y_o  = y_q;
    assign interboard_sel_len_o  = len_q;
    assign interboard_card_o     = card_q;

endmodule

// File: doc/interboard_rx.md
INTERBOARD_RX -- requirements
Module: interboard_rx

Interface
REQ-001 Parameter: TIMEOUT, default 50000, maximum idle cycles between handshake edges inside a packet before it is aborted.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 interboard_rst  input  1  synchronous soft clear, active-high.
REQ-005 rx_req  input  1  request line from the peer board; asynchronous to clk.
REQ-006 rx_data  input  7  word from the peer; bits [5:0] payload, bit [6] odd parity; stable while rx_req is high.
REQ-007 rx_ack  output  1  acknowledge line to the peer.
REQ-008 interboard_en  output  1  one-cycle pulse: a complete, valid message is on the field outputs.
REQ-009 interboard_msg_type  output  4  decoded message type.
REQ-010 interboard_move_dir  output  1  decoded move direction.
REQ-011 interboard_block_x  output  5  decoded block x.
REQ-012 interboard_block_y  output  3  decoded block y.
REQ-013 interboard_sel_len  output  3  decoded selection length.
REQ-014 interboard_card  output  6  decoded card index.
REQ-015 rx_err  output  1  one-cycle pulse on an aborted or rejected packet.

Function
REQ-016 rx_req SHALL pass through a 2-flop synchronizer; only the second flop (req_s) is used by logic.
REQ-017 Protocol SHALL be a 4-phase handshake per word: req_s=1 -> latch rx_data, raise rx_ack; req_s=0 -> drop rx_ack.
REQ-018 A packet SHALL be 4 words in order:
  - W0 = {msg_type[3:0], move_dir, 0}
  - W1 = {0, block_x[4:0]}
  - W2 = {block_y[2:0], sel_len[2:0]}
  - W3 = card[5:0]
REQ-019 FSM states SHALL be RECV (waiting for req_s=1, word index 0..3) and WAIT_REL (rx_ack high, waiting for req_s=0).
REQ-020 Timing: rx_ack SHALL go high on the 3rd rising edge after rx_req rises.
REQ-021 Timing: rx_ack SHALL go low on the 3rd rising edge after rx_req falls.
REQ-022 On release of W3, at the same edge rx_ack drops, all field outputs SHALL update and interboard_en SHALL be high for exactly one cycle.
REQ-023 The word index SHALL then return to 0.
REQ-024 Field outputs SHALL hold their values until the next valid packet.
REQ-025 If W0 msg_type > 8, the packet SHALL be received fully.
REQ-026 In that case interboard_en SHALL NOT pulse, the field outputs SHALL be unchanged, and rx_err SHALL pulse at the edge where interboard_en would have pulsed.
REQ-027 A 17-bit timeout counter SHALL clear on every state change.
REQ-028 In WAIT_REL, and in RECV with index != 0, the counter SHALL increment each cycle.
REQ-029 When the counter reaches TIMEOUT: rx_ack <= 0, index <= 0, state <= RECV, rx_err pulse, outputs unchanged.
REQ-030 RECV with index 0 SHALL wait indefinitely without timing out.
REQ-031 If interboard_rst and a state change coincide, interboard_rst SHALL take precedence.

Reset
REQ-032 While rst=0: state RECV, index 0, synchronizer flops 0, counter 0, rx_ack 0, interboard_en 0, rx_err 0, all field outputs 0.
REQ-033 interboard_rst=1 at an edge SHALL apply the same values synchronously, including mid-packet; a partially received packet is discarded without an rx_err pulse.
REQ-034 After rst deasserts with rx_req already high, the block SHALL treat it as W0 (ack 3 edges later).

Configuration
REQ-035 Macro INTERBOARD_RX_PARITY_EN defined: each latched word SHALL be checked for odd parity over rx_data[6:0].
REQ-036 On a parity failure, the handshake SHALL still complete for that word.
REQ-037 After a parity failure, the packet is marked bad: at W3 release, rx_err pulses instead of interboard_en.
REQ-038 Macro INTERBOARD_RX_PARITY_EN undefined: rx_data[6] SHALL be ignored and no parity logic shall exist.

Verification
REQ-039 Valid packet: W0=0x0E, W1=0x11, W2=0x2B, W3=0x27 with correct parity -> one interboard_en pulse; msg_type=3, move_dir=1, block_x=17, block_y=5, sel_len=3, card=39; rx_ack rises and falls 3 edges after each rx_req edge.
REQ-040 Invalid type: W0 msg_type=12 -> four acks, rx_err pulse, interboard_en stays 0, field outputs keep the previous packet's values.
REQ-041 Timeout: stop after W1 release with TIMEOUT=100 -> rx_err pulse 100 cycles later; a following valid packet decodes correctly.
REQ-042 Mid-packet clear: interboard_rst during W2 WAIT_REL -> rx_ack low next edge, no rx_err; a fresh 4-word packet decodes correctly.
REQ-043 Parity (macro defined): W1 with even parity -> all 4 words acked, rx_err at end, no interboard_en; macro undefined -> same stimulus yields interboard_en.
REQ-044 Async reset: rst low mid-WAIT_REL -> all outputs 0 immediately, without waiting for a clk edge.
